// File: rtl/im2col_skid_buf.sv
// Two-entry valid/ready skid buffer for the im2col SPC datapath. Backpressure is
// absorbed by a skid register so in_ready_o depends only on local state.
module im2col_skid_buf #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [1:0]           occupancy_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     main_q;
  logic [WIDTH-1:0]     skid_q;
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] stall_d;
  logic                 in_fire;
  logic                 out_fire;

  assign in_ready_o  = (state_q != FULL);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // Saturating stall counter; flush does not clear it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
      stall_d = stall_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: non-blocking assignments in every clocked block so all registers
  // sample the same pre-edge state; data registers are reset too, as the
  // output must read zero after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
      if (flush_i) begin
        state_q <= EMPTY;
      end else begin
        unique case (state_q)
          EMPTY: begin
            if (in_fire) begin
              main_q  <= in_data_i;
              state_q <= BUSY;
            end
          end
          BUSY: begin
            if (in_fire && out_fire) begin
              main_q <= in_data_i;
            end else if (in_fire) begin
              skid_q  <= in_data_i;
              state_q <= FULL;
            end else if (out_fire) begin
              state_q <= EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              main_q  <= skid_q;
              state_q <= BUSY;
            end
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

endmodule
